// File: rtl/priority_arbiter_n_pkg.sv
// priority_arbiter_n_pkg
//   Shared definitions for the priority arbiter slice:
//     arb_state_t : two-state grant FSM encoding (IDLE, GRANT)
//     idx_w()     : width of a grant index for an n-input arbiter
package priority_arbiter_n_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Index width for n requesters. The legal range of n starts at 2,
  // so the result is always at least 1.
  function automatic int idx_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/priority_arbiter_n_prio_enc.sv
// prio_enc_n
//   Combinational highest-index-wins priority encoder.
//   Ports:
//     req : N-bit request vector
//     idx : index of the highest set bit of req (0 when req is all zero)
//     any : high when any bit of req is set
module prio_enc_n
  import priority_arbiter_n_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Scan upward so that the last set bit seen, the highest one, wins.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
        idx = IW'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/priority_arbiter_n.sv
// priority_arbiter_n
//   N-input arbiter holding one grant at a time until it is acknowledged.
//   RR_EN=0: fixed priority, highest index wins.
//   RR_EN=1: round-robin, the most recently acked requester gets the
//            lowest priority.
//   Ports:
//     clk        : clock, rising edge
//     rst_n      : asynchronous active-low reset
//     en         : arbitration enable; dropping it aborts a held grant
//     req        : N-bit request vector, bit i = requester i
//     ack        : consumer accepts the current grant
//     gnt_valid  : a grant is held (registered)
//     gnt_idx    : granted index (registered, 0 when no grant)
//     gnt_onehot : granted requester, one-hot (registered, 0 when no grant)
module priority_arbiter_n
  import priority_arbiter_n_pkg::*;
#(
  parameter int N     = 4,
  parameter int RR_EN = 0,
  parameter int IW    = idx_w(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [N-1:0]  req,
  input  logic          ack,
  output logic          gnt_valid,
  output logic [IW-1:0] gnt_idx,
  output logic [N-1:0]  gnt_onehot
);

  arb_state_t    state, state_nxt;
  logic [IW-1:0] last, last_nxt;
  logic [IW-1:0] idx_nxt;
  logic [N-1:0]  onehot_nxt;

  logic [IW-1:0] ptr;
  logic [N-1:0]  req_rot;
  logic [IW-1:0] enc_idx;
  logic          enc_any;
  logic [IW-1:0] win_idx;
  logic [N-1:0]  win_onehot;
  logic          load, clear;

  // Modulo-N reduction for sums of two indices, each already below N.
  function automatic int wrap(input int v);
    return (v >= N) ? v - N : v;
  endfunction

  // On an accepted ack the pointer being written this edge is the
  // acked index, so back-to-back arbitration must already use it.
  always_comb begin
    if (RR_EN == 0) begin
      ptr = '0;
    end else if (state == GRANT && ack) begin
      ptr = gnt_idx;
    end else begin
      ptr = last;
    end
  end

  // Rotate so that index ptr-1 lands on the top bit and index ptr on
  // bit 0; a highest-index search then walks ptr-1, ptr-2, ... ptr.
  always_comb begin
    req_rot = '0;
    for (int j = 0; j < N; j++) begin
      req_rot[j] = req[wrap(j + int'(ptr))];
    end
  end

  prio_enc_n #(
    .N  (N),
    .IW (IW)
  ) u_prio_enc (
    .req (req_rot),
    .idx (enc_idx),
    .any (enc_any)
  );

  always_comb begin
    win_idx = IW'(wrap(int'(enc_idx) + int'(ptr)));
    win_onehot = '0;
    for (int i = 0; i < N; i++) begin
      win_onehot[i] = (win_idx == IW'(i));
    end
  end

  always_comb begin
    state_nxt  = state;
    last_nxt   = last;
    idx_nxt    = gnt_idx;
    onehot_nxt = gnt_onehot;
    load       = 1'b0;
    clear      = 1'b0;

    case (state)
      IDLE: begin
        // ack is meaningless without a grant and is ignored here.
        if (en && enc_any) begin
          state_nxt = GRANT;
          load      = 1'b1;
        end
      end
      GRANT: begin
        if (ack) begin
          // An ack always retires the grant, even alongside en=0.
          last_nxt = gnt_idx;
          if (en && enc_any) begin
            load = 1'b1;
          end else begin
            state_nxt = IDLE;
            clear     = 1'b1;
          end
        end else if (!en) begin
          state_nxt = IDLE;
          clear     = 1'b1;
        end
      end
    endcase

    if (load) begin
      idx_nxt    = win_idx;
      onehot_nxt = win_onehot;
    end
    if (clear) begin
      idx_nxt    = '0;
      onehot_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last       <= '0;
      gnt_idx    <= '0;
      gnt_onehot <= '0;
    end else begin
      state      <= state_nxt;
      last       <= last_nxt;
      gnt_idx    <= idx_nxt;
      gnt_onehot <= onehot_nxt;
    end
  end

  assign gnt_valid = (state == GRANT);

endmodule

// File: tb/tb_priority_arbiter_n.sv
module tb_priority_arbiter_n;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] req;
  logic       ack;

  logic       fx_valid, rr_valid;
  logic [1:0] fx_idx, rr_idx;
  logic [3:0] fx_oh, rr_oh;

  int n_checks = 0;
  int n_errors = 0;

  priority_arbiter_n #(.N(4), .RR_EN(0)) u_fix (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .req        (req),
    .ack        (ack),
    .gnt_valid  (fx_valid),
    .gnt_idx    (fx_idx),
    .gnt_onehot (fx_oh)
  );

  priority_arbiter_n #(.N(4), .RR_EN(1)) u_rr (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .req        (req),
    .ack        (ack),
    .gnt_valid  (rr_valid),
    .gnt_idx    (rr_idx),
    .gnt_onehot (rr_oh)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int rr_seq[5] = '{3, 2, 1, 0, 3};

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    req   = 4'b0000;
    ack   = 1'b0;
    #12;
    check("reset_fx_valid", 32'(fx_valid), 32'h0);
    check("reset_fx_idx",   32'(fx_idx),   32'h0);
    check("reset_fx_oh",    32'(fx_oh),    32'h0);
    check("reset_rr_valid", 32'(rr_valid), 32'h0);
    rst_n = 1'b1;
    step();

    // Fixed priority basic grant
    en  = 1'b1;
    req = 4'b0110;
    step();
    check("fx_0110_valid", 32'(fx_valid), 32'h1);
    check("fx_0110_idx",   32'(fx_idx),   32'h2);
    check("fx_0110_oh",    32'(fx_oh),    32'h4);
    check("rr_0110_idx",   32'(rr_idx),   32'h2);
    en = 1'b0;
    step();
    check("fx_abort_valid", 32'(fx_valid), 32'h0);

    // Round-robin rotation with continuous ack
    en  = 1'b1;
    req = 4'b1111;
    ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("rr_seq%0d_idx", i),   32'(rr_idx),   32'(rr_seq[i]));
      check($sformatf("rr_seq%0d_valid", i), 32'(rr_valid), 32'h1);
      check($sformatf("rr_seq%0d_oh", i),    32'(rr_oh),    32'(4'b0001 << rr_seq[i]));
      check($sformatf("fx_seq%0d_idx", i),   32'(fx_idx),   32'h3);
    end

    // ack together with en=0: pointer moves to 3, then idle
    en = 1'b0;
    step();
    check("rr_ackoff_valid", 32'(rr_valid), 32'h0);
    check("rr_ackoff_idx",   32'(rr_idx),   32'h0);
    ack = 1'b0;
    en  = 1'b1;
    step();
    check("rr_after_ackoff_idx", 32'(rr_idx), 32'h2);
    check("fx_after_ackoff_idx", 32'(fx_idx), 32'h3);
    en = 1'b0;
    step();

    // Grant held stable while req changes without ack
    en  = 1'b1;
    req = 4'b1000;
    step();
    check("fx_hold_first_idx", 32'(fx_idx), 32'h3);
    req = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("fx_hold%0d_idx", i),   32'(fx_idx),   32'h3);
      check($sformatf("fx_hold%0d_valid", i), 32'(fx_valid), 32'h1);
    end
    ack = 1'b1;
    step();
    check("fx_hold_ack_idx",   32'(fx_idx),   32'h0);
    check("fx_hold_ack_valid", 32'(fx_valid), 32'h1);
    check("fx_hold_ack_oh",    32'(fx_oh),    32'h1);
    ack = 1'b0;
    en  = 1'b0;
    step();

    // en=0 blocks arbitration; en drop aborts a held grant
    req = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("en0_valid%0d", i), 32'(fx_valid), 32'h0);
    end
    en = 1'b1;
    step();
    check("en1_valid", 32'(fx_valid), 32'h1);
    check("en1_idx",   32'(fx_idx),   32'h3);
    en = 1'b0;
    step();
    check("en_drop_valid", 32'(fx_valid), 32'h0);
    check("en_drop_oh",    32'(fx_oh),    32'h0);
    check("en_drop_idx",   32'(fx_idx),   32'h0);

    // Asynchronous reset mid-grant; rr pointer is 3 beforehand
    en = 1'b1;
    step();
    check("rr_prerst_idx",   32'(rr_idx),   32'h2);
    check("rr_prerst_valid", 32'(rr_valid), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_rr_valid", 32'(rr_valid), 32'h0);
    check("rst_rr_oh",    32'(rr_oh),    32'h0);
    check("rst_fx_valid", 32'(fx_valid), 32'h0);
    check("rst_fx_oh",    32'(fx_oh),    32'h0);
    rst_n = 1'b1;
    step();
    check("rr_postrst_idx",   32'(rr_idx),   32'h3);
    check("rr_postrst_valid", 32'(rr_valid), 32'h1);
    en = 1'b0;
    step();

    // No requests: ack toggling must not create a grant
    en  = 1'b1;
    req = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      ack = ~ack;
      step();
      check($sformatf("noreq%0d_valid", i), 32'(fx_valid), 32'h0);
      check($sformatf("noreq%0d_idx", i),   32'(fx_idx),   32'h0);
      check($sformatf("noreq%0d_oh", i),    32'(fx_oh),    32'h0);
      check($sformatf("noreq%0d_rr", i),    32'(rr_valid), 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/priority_arbiter_n.md
PRIORITY_ARBITER_N -- requirements
Module: priority_arbiter_n

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the number of request inputs; legal range is 2..32.
REQ-002 The block SHALL have parameter RR_EN, default 0, selecting the mode: 0 = fixed priority, highest index wins; 1 = round-robin.
REQ-003 The block SHALL have parameter IW, default $clog2(N), giving the grant index width.
REQ-004 Port clk: input, 1 bit; the single clock, with all state updated on its rising edge.
REQ-005 Port rst_n: input, 1 bit; reset is asynchronous and active-low.
REQ-006 Port en: input, 1 bit; arbitration enable.
REQ-007 Port req: input, N bits; request vector, where bit i is requester i.
REQ-008 Port ack: input, 1 bit; the consumer accepts the current grant.
REQ-009 Port gnt_valid: output, 1 bit, registered; a grant is held.
REQ-010 Port gnt_idx: output, IW bits, registered; the granted index.
REQ-011 Port gnt_onehot: output, N bits, registered; the granted requester as a one-hot vector.

Function
REQ-012 The block SHALL use a two-state FSM: IDLE (no grant) and GRANT (grant held).
REQ-013 In IDLE, when en=1 and req!=0, the block SHALL register the winner on the next rising edge, set gnt_valid=1 and enter GRANT; latency is 1 cycle.
REQ-014 In IDLE, when en=0 or req==0, the block SHALL keep gnt_valid=0, gnt_idx=0 and gnt_onehot=0.
REQ-015 In fixed mode, the winner SHALL be the highest set index of req.
REQ-016 In round-robin mode, the winner SHALL be the first set bit searching downward from index last-1, wrapping from 0 to N-1, where last is the most recently acked index.
- This gives the acked requester the lowest priority.
REQ-017 The round-robin pointer last SHALL update only on an ack accepted while gnt_valid=1.
- In fixed mode the pointer is unused.
REQ-018 In GRANT, gnt_idx and gnt_onehot SHALL stay stable until ack=1, even if req changes or the granted bit drops.
REQ-019 When ack=1 in GRANT with en=1 and req!=0, the block SHALL load a new winner on the same edge, giving back-to-back grants with gnt_valid held at 1.
- Arbitration uses the current req and the updated pointer.
REQ-020 When ack=1 in GRANT with en=0 or req==0, the block SHALL return to IDLE and clear all outputs on the next edge.
REQ-021 When en=0 in GRANT without ack, the block SHALL abort: return to IDLE and clear the outputs next edge, with the pointer unchanged.
REQ-022 When ack=1 and en=0 occur in the same cycle, the ack SHALL take effect (pointer updates) and the block SHALL then return to IDLE.
REQ-023 The block SHALL ignore ack while in IDLE.
REQ-024 gnt_onehot SHALL always equal the decode of gnt_idx qualified by gnt_valid.

Reset
REQ-025 While rst_n=0, the block SHALL asynchronously force state=IDLE, gnt_valid=0, gnt_idx=0, gnt_onehot=0 and last=0.
- With last=0, the first round-robin search starts at N-1, matching fixed mode.
REQ-026 Asserting reset mid-grant SHALL clear the grant immediately, without waiting for a clock edge.
REQ-027 After rst_n is released, the first arbitration SHALL occur on the first rising edge at which en=1 and req!=0.

Structure
REQ-028 A shared package SHALL hold the FSM state enum (IDLE, GRANT) and the IW width helper function.
REQ-029 One sub-module, prio_enc_n, SHALL be instantiated.
- prio_enc_n is a combinational N-input highest-index priority encoder with outputs idx and any.
- Round-robin mode SHALL be implemented by rotating req by the pointer, encoding with prio_enc_n, then un-rotating the index.
REQ-030 Registers SHALL comprise the state, gnt_idx, gnt_onehot and last; the outputs SHALL have no combinational path from the inputs.

Verification
REQ-031 The bench SHALL cover these directed scenarios, all at N=4:
- RR_EN=0, en=1, req=0110: one cycle later gnt_valid=1, gnt_idx=2, gnt_onehot=0100.
- RR_EN=1, req=1111 held, ack=1 every GRANT cycle: grants are 3,2,1,0,3 with gnt_valid continuously 1.
- RR_EN=0, grant on idx 3, then req changes to 0001 with ack=0 for 5 cycles: gnt_idx stays 3; after ack, gnt_idx=0.
- en=0 with req=1111: gnt_valid stays 0. Then en=1 for one grant, then en=0 without ack: gnt_valid=0 next edge.
- rst_n pulsed low mid-grant between clock edges: gnt_valid=0 and gnt_onehot=0 immediately; with RR_EN=1, the next grant for req=1111 is 3.
- req=0000 with en=1 and ack toggling: gnt_valid, gnt_idx and gnt_onehot remain 0.
